// File: rtl/ibias_ctrl_seq_if.sv
// Purpose : control/status bundle between the pad-ring config side and the bias-cell sequencer.
// Latency : n/a (wiring only).
// Backpr. : none; level requests plus a single-cycle trim load strobe.
// Ports (sequencer view): i_* requests/trim/BG_VALID in, o_* cell pins and status out.
interface ibias_ctrl_seq_if #(
  parameter int N_CH     = 4,
  parameter int TRIM_I_W = 5,
  parameter int TRIM_V_W = 4
);
  logic                i_req_en;
  logic                i_vbias_req;
  logic [N_CH-1:0]     i_ch_req;
  logic [TRIM_I_W-1:0] i_trim_ibias;
  logic [TRIM_V_W-1:0] i_trim_vbias;
  logic                i_trim_ld;
  logic                i_bg_valid;
  logic                o_en_ibias;
  logic                o_en_vbias;
  logic                o_bg_startup;
  logic [TRIM_I_W-1:0] o_trim_ibias;
  logic [TRIM_V_W-1:0] o_trim_vbias;
  logic [N_CH-1:0]     o_ch_en;
  logic                o_ready;
  logic                o_fault;
  logic [2:0]          o_state;

  // Config / cell side: drives requests, observes sequencer outputs.
  modport master (
    output i_req_en, i_vbias_req, i_ch_req, i_trim_ibias, i_trim_vbias, i_trim_ld, i_bg_valid,
    input  o_en_ibias, o_en_vbias, o_bg_startup, o_trim_ibias, o_trim_vbias, o_ch_en,
           o_ready, o_fault, o_state
  );

  // Sequencer side.
  modport slave (
    input  i_req_en, i_vbias_req, i_ch_req, i_trim_ibias, i_trim_vbias, i_trim_ld, i_bg_valid,
    output o_en_ibias, o_en_vbias, o_bg_startup, o_trim_ibias, o_trim_vbias, o_ch_en,
           o_ready, o_fault, o_state
  );
endinterface

// File: rtl/ibias_ctrl_seq.sv
// Purpose : power-up sequencer for the bias/bandgap IO cell; staggers channel-group enables.
// Latency : every output registered; an input seen at a clock edge shows up one cycle later.
// Backpr. : none; requests are levels, trim load is a 1-cycle strobe (deferred while sequencing).
// Ports   : i_clk, i_rst_n (async active-low) plain; everything else via ibias_ctrl_seq_if.slave:
//           i_req_en/i_vbias_req/i_ch_req/i_trim_*/i_trim_ld/i_bg_valid in,
//           o_en_ibias/o_en_vbias/o_bg_startup/o_trim_*/o_ch_en/o_ready/o_fault/o_state out.
module ibias_ctrl_seq #(
  parameter int N_CH        = 4,
  parameter int STARTUP_CYC = 64,
  parameter int SETTLE_CYC  = 256,
  parameter int STAGGER_CYC = 16,
  parameter int TRIM_I_W    = 5,
  parameter int TRIM_V_W    = 4,
  parameter int TRIM_I_RST  = 16,
  parameter int TRIM_V_RST  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  ibias_ctrl_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_STARTUP = 3'd1,
    S_SETTLE  = 3'd2,
    S_RAMP    = 3'd3,
    S_ON      = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  localparam int CNT_MAX_SS = (STARTUP_CYC > SETTLE_CYC) ? STARTUP_CYC : SETTLE_CYC;
  localparam int CNT_MAX    = (CNT_MAX_SS > STAGGER_CYC) ? CNT_MAX_SS : STAGGER_CYC;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  // Terminal counts: the counter runs 0..N-1 for an N-cycle interval.
  localparam logic [CNT_W-1:0] C_STARTUP = CNT_W'(STARTUP_CYC - 1);
  localparam logic [CNT_W-1:0] C_SETTLE  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] C_STAGGER = CNT_W'(STAGGER_CYC - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_en_ibias;
  logic                r_en_vbias;
  logic                r_bg_startup;
  logic [TRIM_I_W-1:0] r_trim_i;
  logic [TRIM_V_W-1:0] r_trim_v;
  logic [TRIM_I_W-1:0] r_pend_i;
  logic [TRIM_V_W-1:0] r_pend_v;
  logic                r_trim_pend;
  logic [N_CH-1:0]     r_ch_en;
  logic                r_ready;
  logic                r_fault;
  logic                r_bgv_low;   // BG_VALID was low last cycle while in RAMP/ON

  logic [N_CH-1:0]     w_ch_kept;   // enabled groups still requested
  logic [N_CH-1:0]     w_pend;      // requested groups not yet enabled
  logic [N_CH-1:0]     w_pend_lo;   // lowest-index pending group (one-hot or zero)
  logic                w_bg_lost;

  assign w_ch_kept = r_ch_en & bus.i_ch_req;
  assign w_pend    = bus.i_ch_req & ~r_ch_en;
  assign w_pend_lo = w_pend & (~w_pend + N_CH'(1));
  assign w_bg_lost = r_bgv_low && !bus.i_bg_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_OFF;
      r_cnt        <= '0;
      r_en_ibias   <= 1'b0;
      r_en_vbias   <= 1'b0;
      r_bg_startup <= 1'b0;
      r_trim_i     <= TRIM_I_W'(TRIM_I_RST);
      r_trim_v     <= TRIM_V_W'(TRIM_V_RST);
      r_pend_i     <= '0;
      r_pend_v     <= '0;
      r_trim_pend  <= 1'b0;
      r_ch_en      <= '0;
      r_ready      <= 1'b0;
      r_fault      <= 1'b0;
      r_bgv_low    <= 1'b0;
    end else begin
      // Trim codes only reach the cell while it is idle or fully up; mid-sequence
      // loads are parked and the latest one is applied on entry to ON.
      if (bus.i_trim_ld) begin
        if (r_state == S_OFF || r_state == S_ON) begin
          r_trim_i    <= bus.i_trim_ibias;
          r_trim_v    <= bus.i_trim_vbias;
          r_trim_pend <= 1'b0;
        end else begin
          r_pend_i    <= bus.i_trim_ibias;
          r_pend_v    <= bus.i_trim_vbias;
          r_trim_pend <= 1'b1;
        end
      end

      r_bgv_low <= (r_state == S_RAMP || r_state == S_ON) && !bus.i_bg_valid;

      if (!bus.i_req_en) begin
        r_state      <= S_OFF;
        r_cnt        <= '0;
        r_en_ibias   <= 1'b0;
        r_en_vbias   <= 1'b0;
        r_bg_startup <= 1'b0;
        r_ch_en      <= '0;
        r_ready      <= 1'b0;
        r_fault      <= 1'b0;
        r_bgv_low    <= 1'b0;
      end else begin
        case (r_state)
          S_OFF: begin
            r_state      <= S_STARTUP;
            r_cnt        <= '0;
            r_en_ibias   <= 1'b1;
            r_en_vbias   <= bus.i_vbias_req;
            r_bg_startup <= 1'b1;
          end

          S_STARTUP: begin
            if (r_cnt >= C_STARTUP) begin
              r_state      <= S_SETTLE;
              r_cnt        <= '0;
              r_bg_startup <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end

          S_SETTLE: begin
            if (r_cnt >= C_SETTLE) begin
              if (bus.i_bg_valid) begin
                // First pending group goes on with the RAMP entry itself. With
                // nothing pending, preload the terminal count so RAMP lasts 1 cycle.
                r_state <= S_RAMP;
                r_ch_en <= w_pend_lo;
                r_cnt   <= (|w_pend) ? '0 : C_STAGGER;
              end else begin
                r_state    <= S_FAULT;
                r_cnt      <= '0;
                r_en_ibias <= 1'b0;
                r_en_vbias <= 1'b0;
                r_ch_en    <= '0;
                r_fault    <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end

          S_RAMP: begin
            if (w_bg_lost) begin
              r_state    <= S_FAULT;
              r_cnt      <= '0;
              r_en_ibias <= 1'b0;
              r_en_vbias <= 1'b0;
              r_ch_en    <= '0;
              r_ready    <= 1'b0;
              r_fault    <= 1'b1;
            end else if (r_cnt >= C_STAGGER) begin
              r_cnt <= '0;
              if (|w_pend) begin
                r_ch_en <= w_ch_kept | w_pend_lo;
              end else begin
                r_ch_en <= w_ch_kept;
                r_state <= S_ON;
                r_ready <= 1'b1;
                // A strobe in this very cycle is newer than anything parked.
                if (bus.i_trim_ld) begin
                  r_trim_i <= bus.i_trim_ibias;
                  r_trim_v <= bus.i_trim_vbias;
                end else if (r_trim_pend) begin
                  r_trim_i <= r_pend_i;
                  r_trim_v <= r_pend_v;
                end
                r_trim_pend <= 1'b0;
              end
            end else begin
              r_ch_en <= w_ch_kept;
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end

          S_ON: begin
            if (w_bg_lost) begin
              r_state    <= S_FAULT;
              r_cnt      <= '0;
              r_en_ibias <= 1'b0;
              r_en_vbias <= 1'b0;
              r_ch_en    <= '0;
              r_ready    <= 1'b0;
              r_fault    <= 1'b1;
            end else if (|w_pend) begin
              r_state <= S_RAMP;
              r_cnt   <= '0;
              r_ch_en <= w_ch_kept | w_pend_lo;
              r_ready <= 1'b0;
            end else begin
              r_ch_en <= w_ch_kept;
            end
          end

          S_FAULT: begin
            // Sticky until the enable request is withdrawn.
            r_cnt <= '0;
          end

          default: begin
            r_state <= S_OFF;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.o_en_ibias   = r_en_ibias;
  assign bus.o_en_vbias   = r_en_vbias;
  assign bus.o_bg_startup = r_bg_startup;
  assign bus.o_trim_ibias = r_trim_i;
  assign bus.o_trim_vbias = r_trim_v;
  assign bus.o_ch_en      = r_ch_en;
  assign bus.o_ready      = r_ready;
  assign bus.o_fault      = r_fault;
  assign bus.o_state      = r_state;

endmodule
